// File: rtl/fst_pkg.sv
// fst_pkg: shared sizes and types for the memory/lock arbiter
package fst_pkg;
  localparam int NCORE = 8;
  localparam int NSLOT = 16;
  localparam int DW = 16;
  typedef logic [$clog2(NCORE)-1:0] core_id_t;
  typedef logic [$clog2(NSLOT)-1:0] slot_t;
  typedef logic [DW-1:0] word_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot round-robin pick, search starts at ptr and wraps
module rr_pick #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic         valid
);
  logic [W-1:0] idx;
  always_comb begin
    gnt = '0;
    valid = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_lock_arbiter.sv
// mem_lock_arbiter: round-robin memory port arbiter plus independent lock-slot arbiter
module mem_lock_arbiter
  import fst_pkg::*;
#(
  parameter int C = NCORE,
  parameter int L = NSLOT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [C-1:0]         main_mem_read_request,
  input  logic [C-1:0]         main_mem_write_request,
  input  word_t [C-1:0]        main_mem_read_adr,
  input  word_t [C-1:0]        main_mem_write_adr,
  input  word_t [C-1:0]        main_mem_write_dat,
  output logic [C-1:0]         main_mem_ac,
  output word_t                mem_read_adr,
  output word_t                mem_write_adr,
  output word_t                mem_write_dat,
  output logic                 mem_write,
  input  slot_t [C-1:0]        lock_adr,
  input  logic [C-1:0]         lock_en,
  input  logic [C-1:0]         unlock_en,
  output logic [C-1:0]         lock_ac
);
  localparam int CW = $bits(core_id_t);
  logic [C-1:0] mreq, mgnt, lreq, lgnt;
  logic mval, lval;
  core_id_t mptr, lptr, midx, lidx;
  logic [L-1:0] busy;
  core_id_t [L-1:0] owner;
  // a core being granted this cycle is hidden so a held request cannot win twice in a row
  assign mreq = (main_mem_read_request | main_mem_write_request) & ~main_mem_ac;
  always_comb begin
    lreq = '0;
    for (int i = 0; i < C; i++) lreq[i] = lock_en[i] & ~busy[lock_adr[i]] & ~lock_ac[i];
  end
  rr_pick #(.N(C), .W(CW)) u_mem_pick (.req(mreq), .ptr(mptr), .gnt(mgnt), .valid(mval));
  rr_pick #(.N(C), .W(CW)) u_lock_pick (.req(lreq), .ptr(lptr), .gnt(lgnt), .valid(lval));
  always_comb begin
    midx = '0;
    lidx = '0;
    for (int i = 0; i < C; i++) begin
      midx = mgnt[i] ? core_id_t'(i) : midx;
      lidx = lgnt[i] ? core_id_t'(i) : lidx;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      main_mem_ac <= '0;
      mem_write <= 1'b0;
      mem_read_adr <= '0;
      mem_write_adr <= '0;
      mem_write_dat <= '0;
      mptr <= '0;
    end else begin
      main_mem_ac <= mgnt;
      mem_write <= mval & main_mem_write_request[midx];
      if (mval) begin
        mptr <= (midx == core_id_t'(C - 1)) ? '0 : midx + 1'b1;
        // write wins over a simultaneous read; the read stays pending
        if (main_mem_write_request[midx]) begin
          mem_write_adr <= main_mem_write_adr[midx];
          mem_write_dat <= main_mem_write_dat[midx];
        end else begin
          mem_read_adr <= main_mem_read_adr[midx];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_ac <= '0;
      busy <= '0;
      owner <= '0;
      lptr <= '0;
    end else begin
      lock_ac <= lgnt;
      for (int i = 0; i < C; i++)
        if (unlock_en[i] && busy[lock_adr[i]] && owner[lock_adr[i]] == core_id_t'(i))
          busy[lock_adr[i]] <= 1'b0;
      if (lval) begin
        busy[lock_adr[lidx]] <= 1'b1;
        owner[lock_adr[lidx]] <= lidx;
        lptr <= (lidx == core_id_t'(C - 1)) ? '0 : lidx + 1'b1;
      end
    end
  end
endmodule

// File: doc/mem_lock_arbiter.md
MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 SHALL have parameter C, default 8, number of requesting cores.
REQ-002 SHALL have parameter L, default 16, number of lock slots; lock address width is log2(L)=4.
REQ-003 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port main_mem_read_request  input  C  per-core read request.
REQ-006 SHALL have port main_mem_write_request  input  C  per-core write request.
REQ-007 SHALL have port main_mem_read_adr  input  C x 16  per-core read address.
REQ-008 SHALL have port main_mem_write_adr  input  C x 16  per-core write address.
REQ-009 SHALL have port main_mem_write_dat  input  C x 16  per-core write data.
REQ-010 SHALL have port main_mem_ac  output  C  one-hot memory grant pulse.
REQ-011 SHALL have port mem_read_adr  output  16  address to memory.
REQ-012 SHALL have port mem_write_adr  output  16  write address to memory.
REQ-013 SHALL have port mem_write_dat  output  16  write data to memory.
REQ-014 SHALL have port mem_write  output  1  write strobe to memory.
REQ-015 SHALL have port lock_adr  input  C x 4  per-core lock slot.
REQ-016 SHALL have port lock_en  input  C  per-core acquire request.
REQ-017 SHALL have port unlock_en  input  C  per-core release (single-cycle pulse).
REQ-018 SHALL have port lock_ac  output  C  one-hot acquire grant pulse.

Function
REQ-019 SHALL grant memory to at most one core per cycle; main_mem_ac registered, high exactly one cycle.
REQ-020 SHALL sample requests in cycle t and assert main_mem_ac[i] plus mem_* outputs in cycle t+1 (latency 1).
REQ-021 SHALL pick the memory winner round-robin: search starts at (last winner+1) mod C; initial pointer 0.
REQ-022 SHALL exclude core i from selection in any cycle where main_mem_ac[i] is high (request still visible that cycle).
REQ-023 SHALL, if core asserts read and write together, perform the write (mem_write=1); read stays pending for a later grant.
REQ-024 SHALL hold mem_write=0 and mem_* addresses/data at last value in cycles with no grant.
REQ-025 SHALL keep per-slot state: busy bit plus 3-bit owner id.
REQ-026 SHALL grant at most one acquire per cycle, round-robin with a pointer independent of the memory pointer.
REQ-027 SHALL treat core i as eligible only if lock_en[i]=1, slot lock_adr[i] not busy (registered state), lock_ac[i]=0.
REQ-028 SHALL on acquire grant set busy/owner at t+1 and pulse lock_ac[i] at t+1.
REQ-029 SHALL on unlock_en[i] clear slot lock_adr[i] at t+1 only if busy and owner==i; otherwise ignore, no error.
REQ-030 SHALL for unlock and lock of the same slot in the same cycle apply the unlock; acquire not granted before the next cycle.
REQ-031 SHALL let a core waiting on a busy slot wait indefinitely, never blocking grants to other slots.
REQ-032 SHALL keep memory and lock arbitration fully independent; both may grant the same core in one cycle.

Reset
REQ-033 SHALL on reset=1 at posedge clear main_mem_ac, lock_ac, mem_write, mem_* data/addresses to 0, all busy bits to 0, both pointers to 0.
REQ-034 SHALL, on reset mid-grant, drop pending pulses the next cycle and drop all held locks.

Structure
REQ-035 SHALL take C, L, data width 16, core id type and lock slot type from shared package fst_pkg.
REQ-036 SHALL instantiate sub-module rr_pick (request vector, pointer -> one-hot winner, valid) twice: memory and lock.

Verification
REQ-037 SHALL test: cores 0,3,5 read-request at adr 0x0010/0x0030/0x0050, held -> ac order 0,3,5, one per cycle, mem_read_adr matches.
REQ-038 SHALL test: all 8 cores request continuously for 16 cycles -> each core granted exactly twice, order 0..7,0..7.
REQ-039 SHALL test: core 2 read+write, write_adr 0x0100 dat 0xBEEF -> first grant mem_write=1 with those values, second grant read.
REQ-040 SHALL test: cores 1 and 4 lock slot 7 same cycle -> lock_ac[1] at t+1; core 4 granted the cycle after core 1 unlocks.
REQ-041 SHALL test: core 6 unlocks slot 7 owned by core 1 -> slot stays busy, owner 1.
REQ-042 SHALL test: reset asserted while slots 0..3 held and grants pending -> next cycle all outputs 0, then slot 0 acquirable.
